// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: captures one command, then applies one 1-bit
// shift/rotate step per clock until the amount is exhausted or abort arrives.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNTW-1:0]  amt,
    input  logic [WIDTH-1:0] operand,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             last_bit,
    output logic             oflow
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {
        M_LSL = 2'b00,
        M_LSR = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_t;

    state_t          state, state_nx;
    mode_t           mode_q;
    logic [CNTW-1:0] cnt;
    logic            accept, step, bit_out;
    logic [WIDTH-1:0] stepped;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // An abort edge performs no step, so the partial result stays as of the previous edge.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNTW'(1)) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bit_out = result[0];
        stepped = {1'b0, result[WIDTH-1:1]};
        unique case (mode_q)
            M_LSL: begin
                bit_out = result[WIDTH-1];
                stepped = {result[WIDTH-2:0], 1'b0};
            end
            M_LSR:   ;
            M_ASR:   stepped = {result[WIDTH-1], result[WIDTH-1:1]};
            M_ROR:   stepped = {result[0], result[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            result   <= '0;
            last_bit <= 1'b0;
            oflow    <= 1'b0;
            cnt      <= '0;
            mode_q   <= M_LSL;
        end else if (accept) begin
            result   <= operand;
            mode_q   <= mode_t'(mode);
            cnt      <= amt;
            last_bit <= 1'b0;
            oflow    <= 1'b0;
        end else if (step) begin
            result   <= stepped;
            cnt      <= cnt - CNTW'(1);
            last_bit <= bit_out;
            if (mode_q != M_ROR) oflow <= oflow | bit_out;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: closed-form reference model plus
// directed scenarios and randomized commands with stray starts and aborts.
module tb_shift_sequencer;
    localparam int W = 8;
    localparam int C = 4;

    logic         clk, clr, start, abort;
    logic [1:0]   mode;
    logic [C-1:0] amt;
    logic [W-1:0] operand;
    logic         busy, done, last_bit, oflow;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(.WIDTH(W), .CNTW(C)) dut (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .amt(amt),
        .operand(operand), .abort(abort), .busy(busy), .done(done),
        .result(result), .last_bit(last_bit), .oflow(oflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    // Outcome of j single-bit steps, computed directly rather than step by step.
    function automatic logic [W+1:0] ref_shift(input logic [W-1:0] op, input logic [1:0] md, input int j);
        logic [63:0]  wide;
        logic [W-1:0] r, low;
        logic         lb, of;
        int           rr;
        if (j == 0) return {op, 2'b00};
        low = (j >= W) ? op : (op & W'((1 << j) - 1));
        r = '0; lb = 1'b0; of = 1'b0;
        case (md)
            2'd0: begin
                wide = 64'(op) << j;
                r    = wide[W-1:0];
                of   = (wide >> W) != 64'd0;
                lb   = (j <= W) ? op[W-j] : 1'b0;
            end
            2'd1: begin
                r  = op >> j;
                of = (low != '0);
                lb = (j <= W) ? op[j-1] : 1'b0;
            end
            2'd2: begin
                r  = W'($signed(op) >>> j);
                of = (low != '0) || (j > W && op[W-1]);
                lb = (j <= W) ? op[j-1] : op[W-1];
            end
            default: begin
                rr = j % W;
                r  = (rr == 0) ? op : W'((op >> rr) | (op << (W - rr)));
                lb = r[W-1];
                of = 1'b0;
            end
        endcase
        return {r, lb, of};
    endfunction

    // Timeline model: command accepted at edge m_k, steps done so far m_j.
    int         e = 0, m_k = 0, m_n = 0, m_j = 0;
    bit         m_active = 1'b0, m_dn = 1'b0;
    logic [W-1:0] m_op = '0;
    logic [1:0] m_mode = 2'd0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_active <= 1'b0; m_dn <= 1'b0; m_op <= '0; m_mode <= 2'd0;
            m_n <= 0; m_j <= 0; m_k <= 0; e <= 0;
        end else begin
            e    <= e + 1;
            m_dn <= 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active <= 1'b1; m_k <= e; m_n <= int'(amt);
                    m_op <= operand; m_mode <= mode; m_j <= 0;
                    m_dn <= (amt == '0);
                end
            end else if (e - m_k <= m_n) begin
                if (abort) m_active <= 1'b0;
                else begin
                    m_j  <= e - m_k;
                    m_dn <= (e - m_k == m_n);
                end
            end else begin
                m_active <= 1'b0;
            end
        end
    end

    logic [W+1:0] exp_v;
    always @(posedge clk) begin
        #1;
        exp_v = ref_shift(m_op, m_mode, m_j);
        check("busy",     32'(busy),     32'(m_active));
        check("done",     32'(done),     32'(m_active & m_dn));
        check("result",   32'(result),   32'(exp_v[W+1:2]));
        check("last_bit", 32'(last_bit), 32'(exp_v[1]));
        check("oflow",    32'(oflow),    32'(exp_v[0]));
    end

    task automatic run_cmd(input logic [W-1:0] op, input logic [1:0] md, input logic [C-1:0] a,
                           output int done_at, output int ndone);
        bit idle_seen;
        @(negedge clk); start = 1'b1; operand = op; mode = md; amt = a;
        @(negedge clk); start = 1'b0;
        done_at = -1; ndone = 0; idle_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin ndone++; if (done_at < 0) done_at = i; end
            if (!busy) begin idle_seen = 1'b1; break; end
            @(negedge clk);
        end
        check("cmd_idle_timeout", 32'(idle_seen), 32'd1);
    endtask

    int da, nd;
    initial begin
        clr = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; amt = '0; operand = '0;
        #1 clr = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_lb_of", 32'({last_bit, oflow}), 32'd0);
        clr = 1'b0;

        check("model_lsr", 32'(ref_shift(8'hF1, 2'd1, 3)),  32'({8'h1E, 1'b0, 1'b1}));
        check("model_lsl", 32'(ref_shift(8'hF1, 2'd0, 2)),  32'({8'hC4, 1'b1, 1'b1}));
        check("model_asr", 32'(ref_shift(8'h80, 2'd2, 3)),  32'({8'hF0, 1'b0, 1'b0}));
        check("model_ror", 32'(ref_shift(8'h01, 2'd3, 9)),  32'({8'h80, 1'b1, 1'b0}));
        check("model_sat", 32'(ref_shift(8'hFF, 2'd1, 15)), 32'({8'h00, 1'b0, 1'b1}));

        run_cmd(8'hF1, 2'd1, 4'd3, da, nd);
        check("lsr_done_at", 32'(da), 32'd3); check("lsr_ndone", 32'(nd), 32'd1);
        check("lsr_res", 32'({result, last_bit, oflow}), 32'({8'h1E, 1'b0, 1'b1}));
        run_cmd(8'hF1, 2'd0, 4'd2, da, nd);
        check("lsl_res", 32'({result, last_bit, oflow}), 32'({8'hC4, 1'b1, 1'b1}));
        run_cmd(8'h80, 2'd2, 4'd3, da, nd);
        check("asr_res", 32'({result, last_bit, oflow}), 32'({8'hF0, 1'b0, 1'b0}));
        run_cmd(8'h01, 2'd3, 4'd9, da, nd);
        check("ror_done_at", 32'(da), 32'd9);
        check("ror_res", 32'({result, last_bit, oflow}), 32'({8'h80, 1'b1, 1'b0}));
        run_cmd(8'hFF, 2'd1, 4'd15, da, nd);
        check("sat_res", 32'({result, oflow}), 32'({8'h00, 1'b1}));

        // Zero amount, start held through DONE then accepted again in IDLE.
        @(negedge clk); start = 1'b1; operand = 8'hA5; mode = 2'd1; amt = '0;
        @(negedge clk);
        check("z_done", 32'(done), 32'd1); check("z_res", 32'({result, oflow}), 32'({8'hA5, 1'b0}));
        operand = 8'h3C;
        @(negedge clk);
        check("z_ign_busy", 32'({busy, done}), 32'd0); check("z_ign_res", 32'(result), 32'hA5);
        @(negedge clk); start = 1'b0;
        check("z_again", 32'({done, result}), 32'({1'b1, 8'h3C}));
        @(negedge clk);

        // Busy rejection followed by abort after the third step.
        @(negedge clk); start = 1'b1; operand = 8'hF0; mode = 2'd1; amt = 4'd6;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; operand = 8'h0F;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("ab_busy", 32'({busy, done}), 32'd0);
        check("ab_res", 32'({result, oflow}), 32'({8'h1E, 1'b0}));
        repeat (3) @(negedge clk);
        check("ab_nodone", 32'({busy, done}), 32'd0);

        // Asynchronous clear between edges in the middle of a command.
        @(negedge clk); start = 1'b1; operand = 8'hB7; mode = 2'd0; amt = 4'd10;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_clr_busy", 32'(busy), 32'd1);
        #3 clr = 1'b1;
        #1;
        check("clr_outs", 32'({busy, done, result, last_bit, oflow}), 32'd0);
        @(negedge clk); clr = 1'b0;
        run_cmd(8'h96, 2'd2, 4'd2, da, nd);
        check("post_clr_res", 32'({result, last_bit, oflow}), 32'({8'hE5, 1'b1, 1'b1}));

        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            start = 1'b1; operand = W'($urandom); mode = 2'($urandom); amt = C'($urandom);
            abort = 1'($urandom);
            @(negedge clk); start = 1'b0; abort = 1'b0;
            for (int c = 0; c < 40 && busy; c++) begin
                start   = ($urandom_range(0, 3) == 0);
                operand = W'($urandom); mode = 2'($urandom); amt = C'($urandom);
                abort   = ($urandom_range(0, 9) == 0);
                @(negedge clk);
            end
            start = 1'b0; abort = 1'b0;
            if (busy) check("rand_timeout", 32'(busy), 32'd0);
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller. It accepts one shift command per handshake: an operand, a mode and an amount.
- It executes the command as a sequence of single-bit shift steps, one step per clock, which is the same 1-bit-per-cycle shifting used elsewhere in the datapath.
- It reports the result, the last bit shifted out and a sticky overflow flag.
- It sits between the ALU control logic and the shift datapath. It owns operand capture, step counting and completion signalling.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNTW, 4, width of the shift-amount field; maximum amount is 2^CNTW-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  command strobe; accepted only in IDLE.
- mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- amt  input  CNTW  number of 1-bit steps.
- operand  input  WIDTH  value to shift.
- abort  input  1  cancels an in-progress command.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  shifted value; held until next accepted start.
- last_bit  output  1  last bit shifted/rotated out.
- oflow  output  1  sticky OR of every bit shifted out during the command; always 0 for rotate.

Behaviour:
- Reset (clr=1, any time, including mid-command):
  - state=IDLE; result=0, last_bit=0, oflow=0, busy=0, done=0.
  - Internal count and captured mode are cleared.
- FSM states: IDLE, SHIFT, DONE. All transitions are registered. busy and done decode directly from the state register.
- IDLE, start=1 sampled at edge k:
  - Capture operand into result, mode into a mode register, amt into the counter.
  - Clear oflow and last_bit.
  - Next state is SHIFT if amt!=0, otherwise DONE.
- SHIFT:
  - Each edge performs exactly one step on result per the captured mode and decrements the counter.
  - When the counter reaches 0 (the edge performing the final step), the next state is DONE.
- Step rules:
  - Left: bit out = result[WIDTH-1]; result = {result[WIDTH-2:0],0}.
  - Logical right: bit out = result[0]; result = {0,result[WIDTH-1:1]}.
  - Arithmetic right: bit out = result[0]; result = {result[WIDTH-1],result[WIDTH-1:1]}.
  - Rotate right: bit out = result[0]; result = {result[0],result[WIDTH-1:1]}.
  - Every step: last_bit <= bit out. For non-rotate modes, oflow <= oflow | bit out.
- Amounts >= WIDTH are legal; steps are simply iterated.
  - Shift modes saturate to all-zeros, or all-sign for arithmetic right.
  - Rotate is effectively amt mod WIDTH.
- Latency: start sampled at edge k, amt=N>0. The N steps occur at edges k+1..k+N. done=1 between edges k+N and k+N+1. State returns to IDLE at edge k+N+1.
  - For N=0: done=1 between edges k and k+1, and result=operand.
- DONE lasts exactly one cycle, then the next state is IDLE unconditionally. start is ignored in DONE.
- start while busy (SHIFT or DONE) is ignored. The command is not queued and in-flight state is unaffected.
- abort=1 in SHIFT: next state is IDLE, no done pulse. result, last_bit and oflow keep their partial values.
  - abort is ignored in IDLE and DONE.
  - abort and start asserted together in IDLE: start wins (abort has no effect in IDLE).
- result, last_bit and oflow remain stable from DONE until the next accepted start.

Test Plan:
- Logical right: operand=8'b11110001, mode=01, amt=3, start at edge 0 -> busy edges 0..4; done only between edges 3 and 4; result=8'b00011110, last_bit=0, oflow=1.
- Left and arithmetic right:
  - operand=8'b11110001, mode=00, amt=2 -> result=8'b11000100, last_bit=1, oflow=1.
  - operand=8'b10000000, mode=10, amt=3 -> result=8'b11110000, last_bit=0, oflow=0.
- Rotate and large amount:
  - operand=8'b00000001, mode=11, amt=9 -> result=8'b10000000, last_bit=1, oflow=0, done 9 edges after the step edges begin.
  - operand=8'hFF, mode=01, amt=15 -> result=0, oflow=1.
- Zero amount and back-to-back: amt=0, operand=8'hA5 -> done in the cycle after start, result=8'hA5, oflow=0. A second start held high during DONE is ignored; the same start reasserted in IDLE is accepted.
- Busy rejection and abort: start mode=01, amt=6, operand=8'hF0; pulse a second start with operand=8'h0F at step 2 -> ignored. Assert abort after step 3 -> no done, busy low next cycle, result=8'h1E, oflow=0.
- Asynchronous reset: assert clr mid-SHIFT between clock edges -> busy, done, result, last_bit and oflow read 0 immediately. After clr deasserts, a new command completes normally.
